// File: rtl/mips_pkg.sv
// Shared MIPS constants used by the register file, decoder and writeback stage.
package mips_pkg;
  localparam int DATA_W       = 32;
  localparam int ADDR_W       = 5;
  localparam int REG_ZERO     = 0;
  localparam int REG_V0       = 2;
  localparam int REG_A0       = 4;
  localparam int SYSCALL_HALT = 10;
endpackage

// File: rtl/regfile_sys_syscall_unit.sv
// Syscall side effects executed in WB: sticky halt, display publish with a
// one-cycle valid pulse, and a wrapping count of non-halting syscalls.
module syscall_unit #(
  parameter int DATA_W    = mips_pkg::DATA_W,
  parameter int HALT_CODE = mips_pkg::SYSCALL_HALT
) (
  input  logic              clk_i,
  input  logic              clear_i,
  input  logic              syscall_i,
  input  logic [DATA_W-1:0] v0_i,
  input  logic [DATA_W-1:0] a0_i,
  output logic              halt_o,
  output logic [DATA_W-1:0] display_o,
  output logic              disp_valid_o,
  output logic [15:0]       sys_count_o
);
  logic              halt_q, halt_d;
  logic [DATA_W-1:0] display_q, display_d;
  logic              disp_valid_q, disp_valid_d;
  logic [15:0]       count_q, count_d;
  logic              fire;

  assign fire = syscall_i && !halt_q;

  always_comb begin
    halt_d       = halt_q;
    display_d    = display_q;
    disp_valid_d = 1'b0;
    count_d      = count_q;
    if (fire) begin
      if (v0_i == DATA_W'(HALT_CODE)) begin
        halt_d = 1'b1;
      end else begin
        display_d    = a0_i;
        disp_valid_d = 1'b1;
        count_d      = count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      halt_q       <= 1'b0;
      display_q    <= '0;
      disp_valid_q <= 1'b0;
      count_q      <= '0;
    end else begin
      halt_q       <= halt_d;
      display_q    <= display_d;
      disp_valid_q <= disp_valid_d;
      count_q      <= count_d;
    end
  end

  assign halt_o       = halt_q;
  assign display_o    = display_q;
  assign disp_valid_o = disp_valid_q;
  assign sys_count_o  = count_q;
endmodule

// File: rtl/regfile_sys.sv
// MIPS register file with same-cycle write-through bypass on both read ports,
// hardwired $0, and the WB-stage syscall unit fed from bypassed $v0/$a0.
module regfile_sys #(
  parameter int DATA_W    = mips_pkg::DATA_W,
  parameter int ADDR_W    = mips_pkg::ADDR_W,
  parameter int HALT_CODE = mips_pkg::SYSCALL_HALT,
  parameter int V0_IDX    = mips_pkg::REG_V0,
  parameter int A0_IDX    = mips_pkg::REG_A0
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] RW,
  input  logic [DATA_W-1:0] RegDin,
  input  logic [ADDR_W-1:0] R1_num,
  input  logic [ADDR_W-1:0] R2_num,
  output logic [DATA_W-1:0] R1,
  output logic [DATA_W-1:0] R2,
  input  logic              SysCall,
  output logic              Halt,
  output logic [DATA_W-1:0] Display,
  output logic              DispValid,
  output logic [15:0]       SysCount
);
  import mips_pkg::*;

  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic              wr_en;
  logic [DATA_W-1:0] v0, a0;

  // Halt gates both the array write and the bypass, so a halted core looks frozen.
  assign wr_en = RegWrite && (RW != ADDR_W'(REG_ZERO)) && !Halt;

  function automatic logic [DATA_W-1:0] byp_read(
    input logic [ADDR_W-1:0] idx,
    input logic [DATA_W-1:0] stored,
    input logic              we,
    input logic [ADDR_W-1:0] widx,
    input logic [DATA_W-1:0] wdata
  );
    if (idx == ADDR_W'(REG_ZERO)) return '0;
    if (we && (widx == idx))      return wdata;
    return stored;
  endfunction

  always_comb begin
    R1 = byp_read(R1_num, regs_q[R1_num], wr_en, RW, RegDin);
    R2 = byp_read(R2_num, regs_q[R2_num], wr_en, RW, RegDin);
    v0 = byp_read(ADDR_W'(V0_IDX), regs_q[V0_IDX], wr_en, RW, RegDin);
    a0 = byp_read(ADDR_W'(A0_IDX), regs_q[A0_IDX], wr_en, RW, RegDin);
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[RW] <= RegDin;
    end
  end

  syscall_unit #(
    .DATA_W   (DATA_W),
    .HALT_CODE(HALT_CODE)
  ) u_syscall (
    .clk_i       (clk),
    .clear_i     (clear),
    .syscall_i   (SysCall),
    .v0_i        (v0),
    .a0_i        (a0),
    .halt_o      (Halt),
    .display_o   (Display),
    .disp_valid_o(DispValid),
    .sys_count_o (SysCount)
  );
endmodule

// File: tb/tb_regfile_sys.sv
// Scoreboard bench for regfile_sys: stimulus queues expectations, a negedge
// monitor pops per-cycle checks and matches every DispValid pulse.
module tb_regfile_sys;
  localparam int K_R1 = 0, K_R2 = 1, K_HALT = 2, K_CNT = 3, K_DV = 4, K_DISP = 5;

  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       name;
  } chk_t;

  typedef struct {
    logic [31:0] disp;
    logic [15:0] cnt;
  } dsp_t;

  logic        clk = 1'b0;
  logic        clear, RegWrite, SysCall;
  logic [4:0]  RW, R1_num, R2_num;
  logic [31:0] RegDin, R1, R2, Display;
  logic        Halt, DispValid;
  logic [15:0] SysCount;

  chk_t chk_q[$];
  dsp_t dsp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  regfile_sys dut (
    .clk(clk), .clear(clear), .RegWrite(RegWrite), .RW(RW), .RegDin(RegDin),
    .R1_num(R1_num), .R2_num(R2_num), .R1(R1), .R2(R2), .SysCall(SysCall),
    .Halt(Halt), .Display(Display), .DispValid(DispValid), .SysCount(SysCount)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    while (chk_q.size() > 0) begin
      chk_t c;
      logic [31:0] act;
      c = chk_q.pop_front();
      case (c.kind)
        K_R1:    act = R1;
        K_R2:    act = R2;
        K_HALT:  act = {31'd0, Halt};
        K_CNT:   act = {16'd0, SysCount};
        K_DV:    act = {31'd0, DispValid};
        default: act = Display;
      endcase
      n_cmp++;
      if (act !== c.exp) begin
        n_bad++;
        $display("FAIL %s: got %h, required %h", c.name, act, c.exp);
      end
    end
    if (DispValid === 1'b1) begin
      n_cmp++;
      if (dsp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_dispvalid: got pulse Display=%h, required no pulse", Display);
      end else begin
        dsp_t d;
        d = dsp_q.pop_front();
        if (Display !== d.disp || SysCount !== d.cnt) begin
          n_bad++;
          $display("FAIL display_pulse: got Display=%h SysCount=%h, required %h/%h",
                   Display, SysCount, d.disp, d.cnt);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_now(input int kind, input logic [31:0] exp, input string name);
    chk_t c;
    c.kind = kind;
    c.exp  = exp;
    c.name = name;
    chk_q.push_back(c);
  endtask

  task automatic expect_pulse(input logic [31:0] disp, input logic [15:0] cnt);
    dsp_t d;
    d.disp = disp;
    d.cnt  = cnt;
    dsp_q.push_back(d);
  endtask

  task automatic idle();
    RegWrite = 1'b0;
    SysCall  = 1'b0;
  endtask

  task automatic wr(input logic [4:0] idx, input logic [31:0] val);
    RegWrite = 1'b1;
    RW       = idx;
    RegDin   = val;
  endtask

  initial begin
    clear = 1'b1; RegWrite = 1'b0; SysCall = 1'b0;
    RW = '0; RegDin = '0; R1_num = '0; R2_num = '0;
    cyc();

    // Reset: writes issued while clear is held must not land.
    for (int i = 0; i < 32; i++) begin
      wr(5'(i), 32'hC0DE_0000 + 32'(i));
      cyc();
    end
    clear = 1'b0;
    idle();
    expect_now(K_HALT, 0, "reset_halt");
    expect_now(K_CNT, 0, "reset_syscount");
    expect_now(K_DV, 0, "reset_dispvalid");
    expect_now(K_DISP, 0, "reset_display");
    for (int i = 0; i < 32; i++) begin
      R1_num = 5'(i);
      R2_num = 5'(31 - i);
      expect_now(K_R1, 0, "reset_r1");
      expect_now(K_R2, 0, "reset_r2");
      cyc();
    end

    // Write / read, and $0 stays zero.
    wr(5, 32'hDEAD_BEEF);
    cyc();
    idle();
    R1_num = 5;
    expect_now(K_R1, 32'hDEAD_BEEF, "write_read_r5");
    cyc();
    wr(0, 32'h0000_1234);
    R1_num = 0;
    expect_now(K_R1, 0, "r0_bypass_blocked");
    cyc();
    idle();
    expect_now(K_R1, 0, "r0_after_write");
    cyc();

    // Same-cycle bypass on port 2.
    wr(7, 32'hA5A5_A5A5);
    R2_num = 7;
    R1_num = 5;
    expect_now(K_R2, 32'hA5A5_A5A5, "bypass_r2");
    expect_now(K_R1, 32'hDEAD_BEEF, "other_port_stored");
    cyc();
    idle();
    expect_now(K_R2, 32'hA5A5_A5A5, "stored_r7");
    cyc();

    // Non-halting syscall publishes $a0.
    wr(2, 1);
    cyc();
    wr(4, 42);
    cyc();
    idle();
    SysCall = 1'b1;
    expect_now(K_DV, 0, "dv_before_pulse");
    expect_pulse(42, 1);
    cyc();
    SysCall = 1'b0;
    cyc();
    expect_now(K_DV, 0, "dv_after_pulse");
    expect_now(K_DISP, 42, "display_held");
    expect_now(K_CNT, 1, "syscount_1");
    cyc();
    // Syscall sees an $a0 written in the same cycle.
    wr(4, 77);
    SysCall = 1'b1;
    expect_pulse(77, 2);
    cyc();
    idle();
    cyc();
    expect_now(K_CNT, 2, "syscount_2");
    cyc();

    // Halt, then ignored writes and syscalls, then clear.
    wr(2, 10);
    cyc();
    idle();
    SysCall = 1'b1;
    expect_now(K_HALT, 0, "halt_not_yet");
    cyc();
    SysCall = 1'b0;
    wr(3, 9);
    R1_num = 3;
    expect_now(K_HALT, 1, "halt_set");
    expect_now(K_CNT, 2, "halt_count_same");
    expect_now(K_DV, 0, "halt_no_pulse");
    expect_now(K_R1, 0, "halted_no_bypass");
    cyc();
    wr(2, 1);
    SysCall = 1'b1;
    R2_num = 2;
    expect_now(K_R1, 0, "halted_r3_unchanged");
    expect_now(K_R2, 10, "halted_r2_no_bypass");
    cyc();
    idle();
    expect_now(K_CNT, 2, "halted_syscall_ignored");
    expect_now(K_DV, 0, "halted_dv_zero");
    expect_now(K_HALT, 1, "halt_sticky");
    expect_now(K_R2, 10, "halted_v0_kept");
    expect_now(K_DISP, 77, "halted_display_kept");
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    expect_now(K_HALT, 0, "clear_halt");
    expect_now(K_CNT, 0, "clear_count");
    expect_now(K_R2, 0, "clear_regs");
    cyc();

    // SysCount wraps 0xFFFF -> 0.
    wr(4, 32'h55);
    cyc();
    idle();
    SysCall = 1'b1;
    for (int k = 0; k < 65536; k++) begin
      expect_pulse(32'h55, 16'(k + 1));
      cyc();
    end
    SysCall = 1'b0;
    expect_now(K_CNT, 0, "syscount_wrap");
    cyc();
    expect_now(K_DV, 0, "wrap_dv_done");
    cyc();

    // Simultaneous write of $v0=10 and syscall halts.
    wr(2, 10);
    SysCall = 1'b1;
    cyc();
    idle();
    R1_num = 2;
    expect_now(K_HALT, 1, "simul_halt");
    expect_now(K_CNT, 0, "simul_count");
    expect_now(K_DV, 0, "simul_no_pulse");
    expect_now(K_R1, 10, "simul_v0_written");
    cyc();

    for (int t = 0; t < 10 && (dsp_q.size() != 0 || chk_q.size() != 0); t++) cyc();
    if (dsp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL missing_pulses: got %0d outstanding, required 0", dsp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
